// File: rtl/liang_pipe_fifo.sv
// liang_pipe_fifo
//   Small synchronous FIFO that sits between pipeline stages, one pc+inst
//   record per entry. Pointers are {flag, value}. The flag toggles each time
//   the value wraps, which lets a full FIFO be told apart from an empty one.
//
// Optional feature macro: LIANG_FIFO_BYPASS_EN
//   When this macro is defined and the FIFO is empty, an offered word is
//   presented on deq_data in the same cycle. If the consumer takes it, the
//   word is never written. When the macro is undefined, there is no
//   combinational path from enq to deq.
//
// Parameters
//   DEPTH : entry count, power of two, >= 2
//   WIDTH : payload bits
// Ports
//   clock                 : sole clock, rising edge
//   reset                 : synchronous, active-high; clears pointers, not storage
//   flush                 : discard all entries (pipeline redirect)
//   enq_valid/enq_ready   : producer handshake; enq_data is the payload in
//   deq_valid/deq_ready   : consumer handshake; deq_data is the payload out
//   count                 : current occupancy, 0..DEPTH
module liang_pipe_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [WIDTH-1:0]           enq_data,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [WIDTH-1:0]           deq_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  // {flag, value} pointers. A plain (AW+1)-bit increment makes the flag toggle
  // on wrap, because DEPTH is a power of two.
  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];

  logic empty_s;
  logic full_s;
  logic bypass_s;
  logic enq_fire_s;
  logic deq_fire_s;
  logic wr_s;
  logic rd_s;

  // Status flags, handshake outputs and pointer-move decisions.
  always_comb begin
    empty_s    = (wptr_r == rptr_r);
    full_s     = (wptr_r[AW-1:0] == rptr_r[AW-1:0]) && (wptr_r[AW] != rptr_r[AW]);
    enq_ready  = !full_s && !flush;
    count      = wptr_r - rptr_r;
`ifdef LIANG_FIFO_BYPASS_EN
    bypass_s   = empty_s && !flush && enq_valid;
`else
    bypass_s   = 1'b0;
`endif
    if (bypass_s) begin
      deq_valid = 1'b1;
      deq_data  = enq_data;
    end else begin
      deq_valid = !empty_s && !flush;
      deq_data  = mem_r[rptr_r[AW-1:0]];
    end
    enq_fire_s = enq_valid && enq_ready;
    deq_fire_s = deq_valid && deq_ready;
    // A bypassed word that the consumer takes never touches storage.
    wr_s       = enq_fire_s && !(bypass_s && deq_ready);
    rd_s       = deq_fire_s && !bypass_s;
  end

  // Pointer registers: reset beats flush, and flush beats transfers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else if (flush) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_s) begin
        wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (rd_s) begin
        rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Entry storage; intentionally not reset.
  always_ff @(posedge clock) begin
    if (wr_s && !reset) begin
      mem_r[wptr_r[AW-1:0]] <= enq_data;
    end
  end

endmodule

// File: tb/tb_liang_pipe_fifo.sv
// Self-checking bench for liang_pipe_fifo (DEPTH=4, WIDTH=32).
// The reference is a queue of words. Expected outputs come from its size and head.
module tb_liang_pipe_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             enq_valid = 1'b0;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_data = 32'h0;
  logic             deq_valid;
  logic             deq_ready = 1'b0;
  logic [WIDTH-1:0] deq_data;
  logic [2:0]       count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  logic [WIDTH-1:0] model_q [$];

`ifdef LIANG_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  liang_pipe_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
    .count(count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model-derived expected outputs for the current state and inputs.
  function automatic bit m_bypass();
    return BYP && (model_q.size() == 0) && !flush && enq_valid;
  endfunction
  function automatic bit m_enq_ready();
    return (model_q.size() < DEPTH) && !flush;
  endfunction
  function automatic bit m_deq_valid();
    return m_bypass() || ((model_q.size() > 0) && !flush);
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("count", {29'd0, count}, model_q.size());
      check("enq_ready", {31'd0, enq_ready}, {31'd0, m_enq_ready()});
      check("deq_valid", {31'd0, deq_valid}, {31'd0, m_deq_valid()});
      if (m_deq_valid())
        check("deq_data", deq_data, m_bypass() ? enq_data : model_q[0]);
    end
  end

  // Model update on the active edge.
  always @(posedge clock) begin
    bit efire;
    bit dfire;
    bit byp;
    if (reset || flush) begin
      model_q.delete();
    end else begin
      byp   = m_bypass();
      efire = enq_valid && m_enq_ready();
      dfire = deq_ready && m_deq_valid();
      if (!(byp && dfire)) begin
        if (dfire) void'(model_q.pop_front());
        if (efire) model_q.push_back(enq_data);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  logic [31:0] exp_words [4];

  initial begin
    exp_words[0] = 32'h11; exp_words[1] = 32'h22;
    exp_words[2] = 32'h33; exp_words[3] = 32'h44;

    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    sample();
    check("rst_enq_ready", {31'd0, enq_ready}, 32'd1);
    check("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);

    // Fill with back-to-back enqueues, consumer stalled.
    tick();
    for (int i = 0; i < 4; i++) begin
      enq_valid = 1'b1; enq_data = exp_words[i];
      tick();
    end
    enq_valid = 1'b0;
    sample();
    check("fill_count", {29'd0, count}, 32'd4);
    check("fill_enq_ready", {31'd0, enq_ready}, 32'd0);
    check("fill_head", deq_data, 32'h11);

    // Drain in order.
    tick();
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("drain_valid", {31'd0, deq_valid}, 32'd1);
      check("drain_data", deq_data, exp_words[i]);
      tick();
    end
    deq_ready = 1'b0;
    sample();
    check("drain_empty_valid", {31'd0, deq_valid}, 32'd0);
    check("drain_empty_count", {29'd0, count}, 32'd0);

    // Streaming across pointer wrap.
    tick();
    enq_valid = 1'b1; deq_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      enq_data = 32'h100 + i;
      sample();
      if (BYP) begin
        check("stream_byp_data", deq_data, 32'h100 + i);
      end else if (i > 0) begin
        check("stream_data", deq_data, 32'h100 + i - 1);
      end
      check("stream_count_le1", {31'd0, (count <= 3'd1)}, 32'd1);
      tick();
    end
    enq_valid = 1'b0;
    if (!BYP) begin
      sample();
      check("stream_last", deq_data, 32'h109);
    end
    tick(); tick();
    deq_ready = 1'b0;

    // Flush with an enqueue offered in the same cycle.
    for (int i = 0; i < 3; i++) begin
      enq_valid = 1'b1; enq_data = 32'h200 + i;
      tick();
    end
    enq_valid = 1'b0;
    sample();
    check("pre_flush_count", {29'd0, count}, 32'd3);
    tick();
    flush = 1'b1; enq_valid = 1'b1; enq_data = 32'hDEAD;
    tick();
    flush = 1'b0; enq_valid = 1'b0;
    sample();
    check("flush_count", {29'd0, count}, 32'd0);
    check("flush_deq_valid", {31'd0, deq_valid}, 32'd0);
    tick();
    enq_valid = 1'b1; enq_data = 32'h55;
    tick();
    enq_valid = 1'b0;
    sample();
    check("post_flush_count", {29'd0, count}, 32'd1);
    check("post_flush_head", deq_data, 32'h55);
    tick();
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;

    // Single word into an empty FIFO with the consumer ready.
    enq_valid = 1'b1; enq_data = 32'hAA; deq_ready = 1'b1;
    sample();
    if (BYP) begin
      check("byp_same_valid", {31'd0, deq_valid}, 32'd1);
      check("byp_same_data", deq_data, 32'hAA);
    end else begin
      check("nobyp_same_valid", {31'd0, deq_valid}, 32'd0);
    end
    tick();
    enq_valid = 1'b0;
    sample();
    if (BYP) begin
      check("byp_next_count", {29'd0, count}, 32'd0);
      check("byp_next_valid", {31'd0, deq_valid}, 32'd0);
    end else begin
      check("nobyp_next_valid", {31'd0, deq_valid}, 32'd1);
      check("nobyp_next_data", deq_data, 32'hAA);
      check("nobyp_next_count", {29'd0, count}, 32'd1);
    end
    tick();
    deq_ready = 1'b0;
    sample();
    check("aa_drained", {29'd0, count}, 32'd0);

    // Reset and flush together with an enqueue offered.
    tick();
    for (int i = 0; i < 2; i++) begin
      enq_valid = 1'b1; enq_data = 32'h300 + i;
      tick();
    end
    enq_valid = 1'b0;
    sample();
    check("pre_rst_count", {29'd0, count}, 32'd2);
    tick();
    reset = 1'b1; flush = 1'b1; enq_valid = 1'b1; enq_data = 32'hBEEF;
    tick();
    reset = 1'b0; flush = 1'b0; enq_valid = 1'b0;
    sample();
    check("rstfl_count", {29'd0, count}, 32'd0);
    check("rstfl_enq_ready", {31'd0, enq_ready}, 32'd1);
    check("rstfl_deq_valid", {31'd0, deq_valid}, 32'd0);

    // Randomized traffic; the per-cycle compare process checks everything.
    tick();
    for (int i = 0; i < 3000; i++) begin
      enq_valid = ($urandom_range(0, 99) < 60);
      deq_ready = ($urandom_range(0, 99) < 50);
      enq_data  = $urandom;
      flush     = ($urandom_range(0, 63) == 0);
      reset     = ($urandom_range(0, 127) == 0);
      tick();
    end
    reset = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
